// File: rtl/wb_bus_arbiter_pkg.sv
// Shared constants for the writeback/CDB arbiter: sizes, FU ids and the
// {valid, rob, rd, result} bus word layout.
package wb_bus_arbiter_pkg;

  localparam int NUM_FU   = 4;
  localparam int NUM_BUS  = 3;
  localparam int PREG_W   = 6;
  localparam int ROB_W    = 6;
  localparam int DATA_W   = 32;
  localparam int FU_IDX_W = $clog2(NUM_FU);

  localparam int BUS_WIDTH      = 1 + ROB_W + PREG_W + DATA_W;
  localparam int BUS_RESULT_LSB = 0;
  localparam int BUS_RESULT_MSB = DATA_W - 1;
  localparam int BUS_RD_LSB     = DATA_W;
  localparam int BUS_RD_MSB     = DATA_W + PREG_W - 1;
  localparam int BUS_ROB_LSB    = DATA_W + PREG_W;
  localparam int BUS_ROB_MSB    = DATA_W + PREG_W + ROB_W - 1;
  localparam int BUS_VALID      = BUS_WIDTH - 1;

  typedef enum logic [FU_IDX_W-1:0] {
    FU_ALU0 = 2'd0,
    FU_ALU1 = 2'd1,
    FU_ALU2 = 2'd2,
    FU_LSU  = 2'd3
  } fu_id_e;

  typedef logic [BUS_WIDTH-1:0] bus_word_t;

  function automatic bus_word_t bus_pack(input logic v, input logic [ROB_W-1:0] rob,
                                         input logic [PREG_W-1:0] rd,
                                         input logic [DATA_W-1:0] data);
    return {v, rob, rd, data};
  endfunction

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// FU completion handshake and CDB broadcast signals of the writeback arbiter.
interface wb_bus_arbiter_if;
  import wb_bus_arbiter_pkg::*;

  logic                       flush;
  logic [NUM_FU-1:0]          fu_valid;
  logic [NUM_FU-1:0]          fu_ready;
  logic [NUM_FU*PREG_W-1:0]   fu_rd;
  logic [NUM_FU*ROB_W-1:0]    fu_rob;
  logic [NUM_FU*DATA_W-1:0]   fu_result;
  logic [ROB_W-1:0]           rob_head;
  logic [NUM_BUS-1:0]         bus_valid;
  logic [NUM_BUS*PREG_W-1:0]  bus_rd;
  logic [NUM_BUS*ROB_W-1:0]   bus_rob;
  logic [NUM_BUS*DATA_W-1:0]  bus_result;
  logic [FU_IDX_W-1:0]        rr_ptr;

  modport slave (
    input  flush, fu_valid, fu_rd, fu_rob, fu_result, rob_head,
    output fu_ready, bus_valid, bus_rd, bus_rob, bus_result, rr_ptr
  );

  modport master (
    output flush, fu_valid, fu_rd, fu_rob, fu_result, rob_head,
    input  fu_ready, bus_valid, bus_rd, bus_rob, bus_result, rr_ptr
  );

endinterface

// File: rtl/wb_bus_arbiter_pick.sv
// Combinational grant picker: up to NUM_BUS requesters, round-robin from a start
// index, or oldest-first by ROB age when WB_AGE_PRIO_EN is defined.
module wb_pick
  import wb_bus_arbiter_pkg::*;
(
  input  logic [NUM_FU-1:0]           req_i,
`ifdef WB_AGE_PRIO_EN
  input  logic [NUM_FU*ROB_W-1:0]     age_i,
`else
  input  logic [FU_IDX_W-1:0]         start_i,
`endif
  output logic [NUM_BUS-1:0]          gnt_vld_o,
  output logic [NUM_BUS*FU_IDX_W-1:0] gnt_idx_o
);

`ifdef WB_AGE_PRIO_EN
  logic [NUM_FU-1:0]   taken;
  logic                found;
  logic [FU_IDX_W-1:0] best;
  logic [ROB_W-1:0]    best_age;

  // Repeated min-search; strict '<' leaves ties with the lower FU index.
  always_comb begin
    gnt_vld_o = '0;
    gnt_idx_o = '0;
    taken     = '0;
    found     = 1'b0;
    best      = '0;
    best_age  = '0;
    for (int b = 0; b < NUM_BUS; b++) begin
      found    = 1'b0;
      best     = '0;
      best_age = '0;
      for (int i = 0; i < NUM_FU; i++) begin
        if (req_i[i] && !taken[i] &&
            (!found || (age_i[i*ROB_W +: ROB_W] < best_age))) begin
          found    = 1'b1;
          best     = FU_IDX_W'(i);
          best_age = age_i[i*ROB_W +: ROB_W];
        end
      end
      if (found) begin
        gnt_vld_o[b]                         = 1'b1;
        gnt_idx_o[b*FU_IDX_W +: FU_IDX_W]    = best;
        taken[best]                          = 1'b1;
      end
    end
  end
`else
  int                  cnt;
  logic [FU_IDX_W-1:0] idx;

  always_comb begin
    gnt_vld_o = '0;
    gnt_idx_o = '0;
    cnt       = 0;
    idx       = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = FU_IDX_W'((int'(start_i) + k) % NUM_FU);
      if (req_i[idx]) begin
        for (int b = 0; b < NUM_BUS; b++) begin
          if (cnt == b) begin
            gnt_vld_o[b]                      = 1'b1;
            gnt_idx_o[b*FU_IDX_W +: FU_IDX_W] = idx;
          end
        end
        cnt = cnt + 1;
      end
    end
  end
`endif

endmodule

// File: rtl/wb_bus_arbiter.sv
// Writeback arbiter: one holding slot per FU, up to NUM_BUS registered CDB grants
// per cycle. Define WB_AGE_PRIO_EN for oldest-first instead of round-robin priority.
module wb_bus_arbiter
  import wb_bus_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  wb_bus_arbiter_if.slave  bus_if
);

  logic [NUM_FU-1:0]          hold_valid_q, hold_valid_d;
  logic [PREG_W-1:0]          hold_rd_q   [NUM_FU];
  logic [ROB_W-1:0]           hold_rob_q  [NUM_FU];
  logic [DATA_W-1:0]          hold_data_q [NUM_FU];
  bus_word_t                  bus_q [NUM_BUS];
  bus_word_t                  bus_d [NUM_BUS];
  logic [FU_IDX_W-1:0]        rr_ptr_q, rr_ptr_d;

  logic [NUM_BUS-1:0]          gnt_vld;
  logic [NUM_BUS*FU_IDX_W-1:0] gnt_idx;
  logic [NUM_FU-1:0]           grant;
  logic [NUM_FU-1:0]           accept;
  logic [FU_IDX_W-1:0]         sel;

`ifdef WB_AGE_PRIO_EN
  logic [NUM_FU*ROB_W-1:0] age;

  // Modular distance from the ROB head handles head wrap-around for free.
  always_comb begin
    age = '0;
    for (int i = 0; i < NUM_FU; i++)
      age[i*ROB_W +: ROB_W] = hold_rob_q[i] - bus_if.rob_head;
  end

  wb_pick u_pick (
    .req_i     (hold_valid_q),
    .age_i     (age),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );
`else
  logic unused_rob_head;
  assign unused_rob_head = ^bus_if.rob_head;

  wb_pick u_pick (
    .req_i     (hold_valid_q),
    .start_i   (rr_ptr_q),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );
`endif

  always_comb begin
    grant = '0;
    for (int b = 0; b < NUM_BUS; b++)
      if (gnt_vld[b]) grant[gnt_idx[b*FU_IDX_W +: FU_IDX_W]] = 1'b1;
  end

  // Ready depends only on registered state and flush, never on fu_valid.
  assign bus_if.fu_ready = {NUM_FU{!bus_if.flush}} & (~hold_valid_q | grant);
  assign accept          = bus_if.fu_valid & bus_if.fu_ready;

  always_comb begin
    hold_valid_d = (hold_valid_q & ~grant) | accept;
    rr_ptr_d     = rr_ptr_q;
    sel          = '0;
    for (int b = 0; b < NUM_BUS; b++) begin
      bus_d[b] = '0;
      if (gnt_vld[b]) begin
        sel      = gnt_idx[b*FU_IDX_W +: FU_IDX_W];
        bus_d[b] = bus_pack(1'b1, hold_rob_q[sel], hold_rd_q[sel], hold_data_q[sel]);
`ifndef WB_AGE_PRIO_EN
        rr_ptr_d = FU_IDX_W'((int'(sel) + 1) % NUM_FU);
`endif
      end
    end
`ifdef WB_AGE_PRIO_EN
    rr_ptr_d = '0;
`endif
    if (bus_if.flush) begin
      hold_valid_d = '0;
      rr_ptr_d     = rr_ptr_q;
      for (int b = 0; b < NUM_BUS; b++) bus_d[b] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= '0;
      rr_ptr_q     <= '0;
      for (int b = 0; b < NUM_BUS; b++) bus_q[b] <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      for (int b = 0; b < NUM_BUS; b++) bus_q[b] <= bus_d[b];
    end
  end

  // Payload needs no reset: it is only observed behind hold_valid_q.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (accept[i]) begin
        hold_rd_q[i]   <= bus_if.fu_rd[i*PREG_W +: PREG_W];
        hold_rob_q[i]  <= bus_if.fu_rob[i*ROB_W +: ROB_W];
        hold_data_q[i] <= bus_if.fu_result[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    bus_if.bus_valid  = '0;
    bus_if.bus_rd     = '0;
    bus_if.bus_rob    = '0;
    bus_if.bus_result = '0;
    for (int b = 0; b < NUM_BUS; b++) begin
      bus_if.bus_valid[b]                    = bus_q[b][BUS_VALID];
      bus_if.bus_rob[b*ROB_W +: ROB_W]       = bus_q[b][BUS_ROB_MSB:BUS_ROB_LSB];
      bus_if.bus_rd[b*PREG_W +: PREG_W]      = bus_q[b][BUS_RD_MSB:BUS_RD_LSB];
      bus_if.bus_result[b*DATA_W +: DATA_W]  = bus_q[b][BUS_RESULT_MSB:BUS_RESULT_LSB];
    end
  end

  assign bus_if.rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: directed literal cases plus randomized traffic checked
// every cycle against a slot/queue level model of the arbitration rules.
module tb_wb_bus_arbiter;
  import wb_bus_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_bus_arbiter_if vif();
  wb_bus_arbiter dut (.clk(clk), .rst(rst), .bus_if(vif));

  int n_checks = 0;
  int n_fail   = 0;

`ifdef WB_AGE_PRIO_EN
  localparam int EXP_PTR_SINGLE = 0;
`else
  localparam int EXP_PTR_SINGLE = 2;
`endif

  // Reference model state: what each FU slot holds and what the buses show.
  bit                m_hv   [NUM_FU];
  logic [PREG_W-1:0] m_rd   [NUM_FU];
  logic [ROB_W-1:0]  m_rob  [NUM_FU];
  logic [DATA_W-1:0] m_res  [NUM_FU];
  int                m_ptr;
  bit                m_bv   [NUM_BUS];
  logic [PREG_W-1:0] m_brd  [NUM_BUS];
  logic [ROB_W-1:0]  m_brob [NUM_BUS];
  logic [DATA_W-1:0] m_bres [NUM_BUS];
  bit                acc_last [NUM_FU];
  int                gq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NUM_FU; i++) begin
      m_hv[i] = 0; acc_last[i] = 0;
    end
    for (int b = 0; b < NUM_BUS; b++) begin
      m_bv[b] = 0; m_brd[b] = '0; m_brob[b] = '0; m_bres[b] = '0;
    end
    m_ptr = 0;
  endfunction

  // Priority order of held slots, then the first NUM_BUS of them win.
  function automatic void build_grants();
    int order[$];
    logic [ROB_W-1:0] ag;
    gq.delete();
`ifdef WB_AGE_PRIO_EN
    for (int a = 0; a < (1 << ROB_W); a++)
      for (int i = 0; i < NUM_FU; i++) begin
        ag = m_rob[i] - vif.rob_head;
        if (m_hv[i] && int'(ag) == a) order.push_back(i);
      end
`else
    for (int k = 0; k < NUM_FU; k++)
      if (m_hv[(m_ptr + k) % NUM_FU]) order.push_back((m_ptr + k) % NUM_FU);
`endif
    foreach (order[j]) if (gq.size() < NUM_BUS) gq.push_back(order[j]);
  endfunction

  always @(negedge clk) begin : cmp
    bit g [NUM_FU];
    logic [NUM_FU-1:0] er;
    if (!rst) begin
      build_grants();
      for (int i = 0; i < NUM_FU; i++) g[i] = 0;
      foreach (gq[j]) g[gq[j]] = 1;
      for (int i = 0; i < NUM_FU; i++) er[i] = !vif.flush && (!m_hv[i] || g[i]);
      check("fu_ready", vif.fu_ready, er);
      check("rr_ptr", vif.rr_ptr, m_ptr);
      for (int b = 0; b < NUM_BUS; b++) begin
        check($sformatf("bus%0d_valid", b), vif.bus_valid[b], m_bv[b]);
        check($sformatf("bus%0d_rd", b), vif.bus_rd[b*PREG_W +: PREG_W], m_brd[b]);
        check($sformatf("bus%0d_rob", b), vif.bus_rob[b*ROB_W +: ROB_W], m_brob[b]);
        check($sformatf("bus%0d_result", b), vif.bus_result[b*DATA_W +: DATA_W], m_bres[b]);
      end
      for (int i = 0; i < NUM_FU; i++) acc_last[i] = vif.fu_valid[i] && er[i];
      for (int b = 0; b < NUM_BUS; b++) begin
        m_bv[b] = 0; m_brd[b] = '0; m_brob[b] = '0; m_bres[b] = '0;
      end
      if (vif.flush) begin
        for (int i = 0; i < NUM_FU; i++) m_hv[i] = 0;
      end else begin
        foreach (gq[j]) begin
          m_bv[j] = 1; m_brd[j] = m_rd[gq[j]]; m_brob[j] = m_rob[gq[j]]; m_bres[j] = m_res[gq[j]];
          m_hv[gq[j]] = 0;
        end
`ifdef WB_AGE_PRIO_EN
        m_ptr = 0;
`else
        if (gq.size() > 0) m_ptr = (gq[gq.size()-1] + 1) % NUM_FU;
`endif
        for (int i = 0; i < NUM_FU; i++)
          if (acc_last[i]) begin
            m_hv[i]  = 1;
            m_rd[i]  = vif.fu_rd[i*PREG_W +: PREG_W];
            m_rob[i] = vif.fu_rob[i*ROB_W +: ROB_W];
            m_res[i] = vif.fu_result[i*DATA_W +: DATA_W];
          end
      end
    end
  end

  task automatic set_fu(input int i, input bit v, input logic [31:0] rd,
                        input logic [31:0] rob, input logic [31:0] res);
    vif.fu_valid[i]                     = v;
    vif.fu_rd[i*PREG_W +: PREG_W]       = rd[PREG_W-1:0];
    vif.fu_rob[i*ROB_W +: ROB_W]        = rob[ROB_W-1:0];
    vif.fu_result[i*DATA_W +: DATA_W]   = res;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NUM_FU; i++) set_fu(i, 0, 0, 0, 0);
  endtask

  task automatic drive_random();
    for (int i = 0; i < NUM_FU; i++)
      if (!(vif.fu_valid[i] && !acc_last[i]))
        set_fu(i, ($urandom_range(0, 99) < 55), $urandom_range(0, 63),
               $urandom_range(0, 63), $urandom);
    vif.flush    = ($urandom_range(0, 24) == 0);
    vif.rob_head = ROB_W'($urandom_range(0, 63));
  endtask

  initial begin
    rst = 1'b1;
    vif.flush = 1'b0; vif.rob_head = '0;
    vif.fu_valid = '0; vif.fu_rd = '0; vif.fu_rob = '0; vif.fu_result = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset_bus_valid", vif.bus_valid, 3'b000);
    check("reset_fu_ready", vif.fu_ready, 4'b1111);
    check("reset_rr_ptr", vif.rr_ptr, 0);

    // Contention: all four FUs complete together, FU3 waits a cycle.
    for (int i = 0; i < NUM_FU; i++) set_fu(i, 1, 10 + i, i, 1000 + i);
    tick();
    idle_all();
    #1 check("cont_fu_ready", vif.fu_ready, 4'b0111);
    tick();
    check("cont_c1_valid", vif.bus_valid, 3'b111);
    check("cont_c1_bus0_rd", vif.bus_rd[0 +: PREG_W], 10);
    check("cont_c1_bus1_rd", vif.bus_rd[PREG_W +: PREG_W], 11);
    check("cont_c1_bus2_res", vif.bus_result[2*DATA_W +: DATA_W], 1002);
    tick();
    check("cont_c2_valid", vif.bus_valid, 3'b001);
    check("cont_c2_bus0_res", vif.bus_result[0 +: DATA_W], 1003);
    check("cont_c2_rr_ptr", vif.rr_ptr, 0);
    tick();

    // Single uncontended result from FU1.
    set_fu(1, 1, 5, 3, 42);
    tick();
    idle_all();
    tick();
    check("single_valid", vif.bus_valid, 3'b001);
    check("single_rd", vif.bus_rd[0 +: PREG_W], 5);
    check("single_rob", vif.bus_rob[0 +: ROB_W], 3);
    check("single_result", vif.bus_result[0 +: DATA_W], 42);
    check("single_rr_ptr", vif.rr_ptr, EXP_PTR_SINGLE);
    tick();

    // Back-to-back FU0 completions, one per cycle.
    for (int c = 0; c < 6; c++) begin
      set_fu(0, 1, c, c, 100 + c);
      tick();
      check("b2b_ready", vif.fu_ready[0], 1'b1);
      if (c > 0) begin
        check("b2b_valid", vif.bus_valid, 3'b001);
        check("b2b_result", vif.bus_result[0 +: DATA_W], 100 + c - 1);
      end
    end
    idle_all();
    tick(); tick();

    // Flush with an FU2 entry held and a new FU2 result offered.
    set_fu(2, 1, 7, 7, 77);
    tick();
    vif.flush = 1'b1;
    set_fu(2, 1, 8, 8, 88);
    #1 check("flush_ready", vif.fu_ready, 4'b0000);
    tick();
    vif.flush = 1'b0;
    idle_all();
    check("flush_bus_c1", vif.bus_valid, 3'b000);
    tick();
    check("flush_bus_c2", vif.bus_valid, 3'b000);

`ifdef WB_AGE_PRIO_EN
    vif.rob_head = 6'd62;
    set_fu(0, 1, 1, 1, 501); set_fu(1, 1, 2, 63, 502);
    set_fu(2, 1, 3, 62, 503); set_fu(3, 1, 4, 0, 504);
    tick();
    idle_all();
    tick();
    check("age_bus0_rob", vif.bus_rob[0 +: ROB_W], 62);
    check("age_bus1_rob", vif.bus_rob[ROB_W +: ROB_W], 63);
    check("age_bus2_rob", vif.bus_rob[2*ROB_W +: ROB_W], 0);
    tick();
    check("age_next_rob", vif.bus_rob[0 +: ROB_W], 1);
    check("age_next_valid", vif.bus_valid, 3'b001);
    vif.rob_head = '0;
    tick();
`endif

    // Asynchronous reset in the middle of a cycle with entries held.
    for (int i = 0; i < NUM_FU; i++) set_fu(i, 1, 20 + i, i, 200 + i);
    tick();
    tick();
    idle_all();
    #1 rst = 1'b1;
    model_reset();
    #1;
    check("midrst_bus_valid", vif.bus_valid, 3'b000);
    check("midrst_fu_ready", vif.fu_ready, 4'b1111);
    check("midrst_rr_ptr", vif.rr_ptr, 0);
    rst = 1'b0;
    tick();

    // Randomized traffic against the model.
    repeat (400) begin
      drive_random();
      tick();
    end
    vif.flush = 1'b0;
    idle_all();
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Shares the result broadcast buses (CDB) between the functional units: 3 ALUs plus the load/store unit.
- Each FU completes into a one-entry holding slot through a valid/ready handshake.
- Each cycle the arbiter grants up to NUM_BUS held results and drives them onto registered bus outputs.
- The buses feed RS wakeup, the ROB complete-marking and the PRF write.

Parameters:
- NUM_FU, 4, number of requesting functional units (ALU0-2, LSU).
- NUM_BUS, 3, number of broadcast buses.
- PREG_W, 6, physical register tag width.
- ROB_W, 6, ROB index width.
- DATA_W, 32, result width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  pipeline flush; discards all pending results.
- fu_valid  in  NUM_FU  FU i presents a completed result.
- fu_ready  out  NUM_FU  FU i's result is accepted this cycle.
- fu_rd  in  NUM_FU*PREG_W  destination physical tags, FU i at slice i.
- fu_rob  in  NUM_FU*ROB_W  ROB indices.
- fu_result  in  NUM_FU*DATA_W  result data.
- rob_head  in  ROB_W  oldest ROB index; used only with WB_AGE_PRIO_EN.
- bus_valid  out  NUM_BUS  bus j carries a result.
- bus_rd  out  NUM_BUS*PREG_W  bus destination tags.
- bus_rob  out  NUM_BUS*ROB_W  bus ROB indices.
- bus_result  out  NUM_BUS*DATA_W  bus data.
- rr_ptr  out  clog2(NUM_FU)  current round-robin start index (debug).

Behaviour:
- State per FU: hold_valid, hold_rd, hold_rob, hold_data. Also rr_ptr and the bus output registers.
- Reset (async): hold_valid=0, rr_ptr=0, all bus_* outputs = 0.
- Selection is combinational from registered state only:
  - Scan FU indices starting at rr_ptr, incrementing mod NUM_FU.
  - The first up-to-NUM_BUS entries with hold_valid=1 are granted.
  - The k-th grant in scan order drives bus k.
- fu_ready[i] = !flush && (!hold_valid[i] || grant[i]). There is no combinational path from fu_valid to fu_ready.
- Each posedge (no flush):
  - Granted slots load the bus registers with bus_valid=1.
  - Unused bus slots: valid=0, rd/rob/result=0.
  - Granted hold entries clear.
  - If fu_valid[i] && fu_ready[i], the hold entry captures fu_rd/fu_rob/fu_result. Capture and grant-clear in the same cycle leave the new entry valid.
  - rr_ptr becomes (index of last granted FU + 1) mod NUM_FU if any grant occurred; otherwise it is unchanged.
- Latency: a result accepted at edge N appears on a bus at edge N+1 when uncontended. Each FU has a throughput of one result per cycle under no contention.
- Starvation-free: an entry waits at most ceil((NUM_FU-1)/NUM_BUS) cycles.
- NUM_BUS >= NUM_FU: every held entry is granted every cycle, and rr_ptr still advances per the rule above.
- Flush:
  - At the edge, all hold_valid=0 and all bus_valid=0.
  - fu_ready=0 during the flush cycle, so no capture occurs.
  - rr_ptr is retained.
- Reset mid-operation: all pending results are lost immediately and outputs return to reset values asynchronously.
- Each result is broadcast exactly once. Results are never duplicated or reordered within a single FU.

Optional Feature:
- Macro: WB_AGE_PRIO_EN.
- Defined:
  - Priority is oldest-first by age = (hold_rob - rob_head) mod 2^ROB_W; smaller age wins.
  - Ties (impossible in legal use) go to the lower FU index.
  - rr_ptr is held at 0.
  - rob_head wrap-around must be handled by the modular subtraction.
- Undefined: round-robin as above; rob_head is ignored.

Decomposition:
- Add to the shared bus constants header:
  - BUS_WIDTH and field ranges BUS_VALID, BUS_ROB, BUS_RD, BUS_RESULT, matching the bus packing {valid, rob, rd, result}.
  - FU index constants FU_ALU0..FU_LSU.
- One combinational sub-module, wb_pick, is natural:
  - Inputs: request vector, start pointer (or age keys).
  - Outputs: a NUM_BUS-deep list of granted indices with valid bits.

Test Plan:
- Reset: assert rst mid-cycle with entries held -> bus_valid=0, fu_ready=4'b1111, rr_ptr=0 immediately.
- Single result: FU1 valid rd=6'd5, rob=3, result=32'd42 at cycle 0 -> bus0 valid rd=5, rob=3, result=42 at cycle 1; rr_ptr=2.
- Contention: all 4 FUs valid at cycle 0 with rr_ptr=0 ->
  - cycle 1: buses 0/1/2 carry FU0/1/2 and FU3 sees fu_ready=0.
  - cycle 2: bus0 carries FU3; rr_ptr=0.
- Back-to-back: FU0 valid every cycle with the others idle -> one FU0 result on bus0 per cycle, fu_ready[0] held 1.
- Flush: held FU2 entry and flush=1 -> next cycle bus_valid=0, hold cleared, and the FU2 input presented during flush is not accepted.
- WB_AGE_PRIO_EN with rob_head=62 and held robs FU0=1, FU1=63, FU2=62, FU3=0 -> first grant cycle carries 62, 63, 0 and FU0 (rob 1) follows in the next cycle.
